// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int CNT_W = 4;

    // Byte-lane enables for an access of the given size at the given low address bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lo;
            SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered word read.
// Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-enabled write and synchronous read of one word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request, configurable wait states,
// byte/half/word access with sign or zero extension, error response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned half/word accesses
// become errors; when undefined they are forced to natural alignment).
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | ready for a request
// ST_WAIT | legal access accepted, counting down wait states
// ST_RESP | one-cycle response strobe
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             we_q, signed_q, err_q;
    logic [1:0]       size_q;
    logic [AW+1:0]    addr_q;
    logic [31:0]      wdata_q;

    logic             size_bad, range_bad, align_bad, req_err;
    logic [AW+1:0]    addr_eff;
    logic             accept, enter_resp, mem_go;

    logic             op_we;
    logic [1:0]       op_size;
    logic [AW+1:0]    op_addr;
    logic [31:0]      op_wdata, wr_lanes;
    logic [3:0]       op_be;
    logic [31:0]      rd_word, lane_data, ext_data;

    assign accept = req_valid && (state == ST_IDLE);

    // Classify the incoming request and compute its effective byte address.
    always_comb begin
        size_bad  = (req_size == 2'b11);
        range_bad = (req_addr[31:2] >= 30'(DEPTH_WORDS));
        addr_eff  = req_addr[AW+1:0];
`ifdef DMEM_ALIGN_CHECK_EN
        align_bad = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        align_bad = 1'b0;
        if (req_size == SZ_HALF) begin
            addr_eff[0] = 1'b0;
        end else if (req_size == SZ_WORD) begin
            addr_eff[1:0] = 2'b00;
        end
`endif
        req_err = size_bad || range_bad || align_bad;
    end

    // Next-state logic; enter_resp marks the edge that commits a legal access.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_nx = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nx   = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx   = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, counter and request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                err_q    <= req_err;
                size_q   <= req_size;
                addr_q   <= addr_eff;
                wdata_q  <= req_wdata;
            end
        end
    end

    // With zero wait states the storage access happens on the accept edge itself,
    // so the live request is used there; otherwise the captured copy.
    always_comb begin
        if (state == ST_IDLE) begin
            op_we    = req_we;
            op_size  = req_size;
            op_addr  = addr_eff;
            op_wdata = req_wdata;
        end else begin
            op_we    = we_q;
            op_size  = size_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
        op_be = lane_mask(op_size, op_addr[1:0]);
        case (op_size)
            SZ_BYTE: wr_lanes = {4{op_wdata[7:0]}};
            SZ_HALF: wr_lanes = {2{op_wdata[15:0]}};
            default: wr_lanes = op_wdata;
        endcase
    end

    // A reset on the commit edge drops the access.
    assign mem_go = enter_resp && !reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .wr_en(mem_go && op_we),
        .rd_en(mem_go && !op_we),
        .addr (op_addr[AW+1:2]),
        .be   (op_be),
        .wdata(wr_lanes),
        .rdata(rd_word)
    );

    // Shift the addressed lane down and extend it.
    always_comb begin
        lane_data = rd_word >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: ext_data = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                         : {24'h0, lane_data[7:0]};
            SZ_HALF: ext_data = signed_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                         : {16'h0, lane_data[15:0]};
            default: ext_data = rd_word;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ext_data : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: instance 0 with 3 wait states, instance 1 with none.
// A byte-level memory model predicts every response; directed tests pin literals.
module tb_dmem_ctrl;

    localparam int DEPTH = 64;
    localparam int W0    = 3;
    localparam int W1    = 0;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting, got no event, expected one (cycle %0d)", name, cyc);
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic logic [31:0] pat(input int w);
        return (32'h01010101 * w) ^ 32'hC3C3C3C3;
    endfunction

    // ---------------- behavioural model ----------------
    logic        pend [2] = '{1'b0, 1'b0};
    int          due  [2];
    logic        p_we [2], p_sg [2], p_err [2];
    logic [1:0]  p_sz [2];
    logic [31:0] p_ad [2], p_wd [2];
    logic [7:0]  mref [2][256];

    logic        m_ready, m_valid;
    logic [31:0] m_data;
    int          m_a;

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] ad);
        logic e;
        e = (sz == 2'd3) || ((ad >> 2) >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (sz == 2'd1 && ad[0]) e = 1'b1;
        if (sz == 2'd2 && ad[1:0] != 2'd0) e = 1'b1;
`endif
        return e;
    endfunction

    // Compare process: ready/valid every cycle, data and error on each response.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_ready = !pend[i];
            m_valid = pend[i] && (due[i] == cyc);
            chk($sformatf("req_ready%0d", i), {31'b0, req_ready[i]}, {31'b0, m_ready});
            chk($sformatf("rsp_valid%0d", i), {31'b0, rsp_valid[i]}, {31'b0, m_valid});
            if (m_valid) begin
                m_data = 32'h0;
                if (!p_err[i]) begin
                    m_a = int'(p_ad[i][7:0]);
                    if (p_sz[i] == 2'd1) m_a = m_a & ~1;
                    if (p_sz[i] == 2'd2) m_a = m_a & ~3;
                    if (p_we[i]) begin
                        mref[i][m_a] = p_wd[i][7:0];
                        if (p_sz[i] != 2'd0) mref[i][m_a+1] = p_wd[i][15:8];
                        if (p_sz[i] == 2'd2) begin
                            mref[i][m_a+2] = p_wd[i][23:16];
                            mref[i][m_a+3] = p_wd[i][31:24];
                        end
                    end else if (p_sz[i] == 2'd0) begin
                        m_data = {24'h0, mref[i][m_a]};
                        if (p_sg[i] && m_data[7]) m_data = m_data | 32'hFFFFFF00;
                    end else if (p_sz[i] == 2'd1) begin
                        m_data = {16'h0, mref[i][m_a+1], mref[i][m_a]};
                        if (p_sg[i] && m_data[15]) m_data = m_data | 32'hFFFF0000;
                    end else begin
                        m_data = {mref[i][m_a+3], mref[i][m_a+2], mref[i][m_a+1], mref[i][m_a]};
                    end
                end
                chk($sformatf("rsp_rdata%0d", i), rsp_rdata[i], m_data);
                chk($sformatf("rsp_err%0d", i), {31'b0, rsp_err[i]}, {31'b0, p_err[i]});
                pend[i] = 1'b0;
            end
            if (rst[i]) begin
                pend[i] = 1'b0;
            end else if (m_ready && req_valid[i]) begin
                pend[i]  = 1'b1;
                p_we[i]  = req_we[i];
                p_sg[i]  = req_signed[i];
                p_sz[i]  = req_size[i];
                p_ad[i]  = req_addr[i];
                p_wd[i]  = req_wdata[i];
                p_err[i] = model_err(req_size[i], req_addr[i]);
                due[i]   = cyc + 1 + (p_err[i] ? 0 : wait_of(i));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int i, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(posedge clk); #1;
        req_we[i] = we; req_size[i] = sz; req_signed[i] = sg;
        req_addr[i] = ad; req_wdata[i] = wd; req_valid[i] = 1'b1;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) timeout("req_accept");
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        lat = 1;
        while (!rsp_valid[i] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid[i]) timeout("rsp_wait");
        rd = rsp_rdata[i];
        er = rsp_err[i];
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, seen, acc, last, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
            req_signed[i] = 1'b0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", {31'b0, req_ready[i]}, 32'd1);
            chk("reset_valid", {31'b0, rsp_valid[i]}, 32'd0);
            chk("reset_rdata", rsp_rdata[i], 32'h0);
            chk("reset_err", {31'b0, rsp_err[i]}, 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int w = 0; w < DEPTH; w++) do_req(0, 1'b1, 2'd2, 1'b0, 32'(w * 4), pat(w), rd, er, lat);

        do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("st_word_err", {31'b0, er}, 32'd0);
        chk("st_word_lat", 32'(lat), 32'd4);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("ld_word_data", rd, 32'hDEADBEEF);
        chk("ld_word_err", {31'b0, er}, 32'd0);
        chk("ld_word_lat", 32'(lat), 32'd4);

        do_req(0, 1'b1, 2'd0, 1'b0, 32'h12, 32'hAAAAAA55, rd, er, lat);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("ld_after_sb", rd, 32'hDE55BEEF);
        do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat);
        chk("ld_sbyte", rd, 32'hFFFFFFDE);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat);
        chk("ld_uhalf", rd, 32'h0000DE55);

        do_req(0, 1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, rd, er, lat);
        chk("oor_err", {31'b0, er}, 32'd1);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_lat", 32'(lat), 32'd1);

        do_req(0, 1'b1, 2'd3, 1'b0, 32'h30, 32'hFFFFFFFF, rd, er, lat);
        chk("sz11_err", {31'b0, er}, 32'd1);
        chk("sz11_lat", 32'(lat), 32'd1);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat);
        chk("sz11_unchanged", rd, 32'hCFCFCFCF);

        do_req(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_half_err", {31'b0, er}, 32'd1);
`else
        chk("mis_half_u", rd, 32'h0000BEEF);
`endif
        do_req(0, 1'b0, 2'd1, 1'b1, 32'h11, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_half_s_err", {31'b0, er}, 32'd1);
`else
        chk("mis_half_s", rd, 32'hFFFFBEEF);
`endif

        // Reset two cycles after accepting a store: no response, store dropped.
        @(posedge clk); #1;
        req_we[0] = 1'b1; req_size[0] = 2'd2; req_signed[0] = 1'b0;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h00001234; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid[0]) seen++;
            @(posedge clk); #1;
        end
        chk("rst_wait_no_rsp", 32'(seen), 32'd0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("rst_wait_old", rd, 32'hCBCBCBCB);

        // Zero wait states, request held continuously, alternating store/load.
        @(posedge clk); #1;
        req_we[1] = 1'b1; req_size[1] = 2'd2; req_signed[1] = 1'b0;
        req_addr[1] = 32'h40; req_wdata[1] = 32'h10000000; req_valid[1] = 1'b1;
        acc = 0; last = -1; n = 0;
        while (acc < 8 && n < 60) begin
            @(posedge clk); #1; n++;
            if (rsp_valid[1]) begin
                acc++;
                if (last >= 0) chk("b2b_gap", 32'(n - last), 32'd2);
                last = n;
                chk("b2b_ready_low", {31'b0, req_ready[1]}, 32'd0);
                req_we[1] = !req_we[1];
                if (req_we[1]) req_wdata[1] = 32'h10000000 + 32'(acc);
            end
        end
        req_valid[1] = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd8);

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
